ant_agc_align: RTL and testbench
================================

# ant_agc_align

Per-symbol exponent alignment stage placed directly downstream of the even/odd antenna data buffer. It consumes the buffer's paired even/odd antenna-group RE stream, together with the per-group FFT AGC exponents. It right-shifts the group with the smaller exponent so that both groups share one common exponent, and checks symbol framing. It emits one merged 2*ANT-antenna RE stream to the dimension-reduction datapath.

## Interface
Parameters:
- ANT, 4, antennas per group; each sample is 32 bits {Q[31:16], I[15:0]}, both signed two's complement.
- ADDR_WIDTH, 11, width of the RE address.
- RE_NUM, 1584, number of REs per symbol (132 PRB * 12).
- ERR_WIDTH, 16, width of the framing error counter.

Ports (one clock; reset is synchronous and active-low):
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_ant_even  in  ANT*32  even-group samples.
- i_ant_odd  in  ANT*32  odd-group samples.
- i_ant_addr  in  ADDR_WIDTH  RE index of the current beat.
- i_ant_sop  in  1  first RE of a symbol; qualified by i_tvalid.
- i_ant_eop  in  1  last RE of a symbol; qualified by i_tvalid.
- i_tvalid  in  1  beat valid; there is no backpressure.
- i_info_1  in  16  {odd_agc[15:8], even_agc[7:0]}, unsigned exponents; sampled on the SOP beat only.
- i_slot_idx  in  7  slot index; sampled on the SOP beat.
- i_symb_idx  in  4  symbol index; sampled on the SOP beat.
- o_ant_data  out  2*ANT*32  aligned samples {odd group, even group}, with even antenna 0 in the LSBs.
- o_exp  out  8  common exponent of the current symbol.
- o_slot_idx  out  7  latched slot index.
- o_symb_idx  out  4  latched symbol index.
- o_sop  out  1  first output beat of a symbol.
- o_eop  out  1  last output beat of a symbol.
- o_tvalid  out  1  output beat valid.
- o_frm_err  out  1  one-cycle pulse on a framing error.
- o_err_cnt  out  ERR_WIDTH  saturating count of framing errors.

## Operation
- FSM, state IDLE:
  - Beats without SOP are dropped. Each dropped beat pulses o_frm_err and increments o_err_cnt.
  - On tvalid&&sop: latch the exponents, slot and symbol; set re_cnt=0; go to RUN. The SOP beat is processed.
- FSM, state RUN: every valid beat is processed, then re_cnt increments.
  - i_ant_addr != re_cnt: error pulse; the beat is still forwarded.
  - eop with re_cnt==RE_NUM-1: clean end; go to IDLE.
  - eop with re_cnt!=RE_NUM-1: the beat is forwarded with o_eop=1, error pulse, go to IDLE.
  - re_cnt==RE_NUM-1 without eop: the beat is forwarded with o_eop forced to 1, error pulse, go to IDLE.
  - sop arriving in RUN: error pulse. The beat starts a new symbol: relatch exponents and indices, re_cnt=0. The previous symbol gets no o_eop.
- At most one error is counted per cycle. o_err_cnt saturates at all-ones.
- Alignment per symbol:
  - e_max = max(even_agc, odd_agc); o_exp = e_max.
  - d_even = e_max - even_agc and d_odd = e_max - odd_agc (8-bit, one of them is 0).
  - Each I and Q of a group is processed independently:
    - d=0: pass through unchanged.
    - 1<=d<=15: y = (x + 2^(d-1)) >>> d, computed in 17 bits. The result always fits 16 bits, so no saturation is needed.
    - d>=16: y = 0.
- o_slot_idx, o_symb_idx and o_exp are registered and stay constant between SOPs.

## Timing
- Latency is 3 cycles from input beat to output beat.
  - Stage 1: register data and compute shift amounts.
  - Stage 2: rounding add.
  - Stage 3: arithmetic shift and output register.
- o_sop, o_eop and o_tvalid are delayed by the same 3 stages.
- o_sop/o_eop are only asserted together with o_tvalid.
- o_frm_err is asserted 1 cycle after the offending input beat. It is not aligned with the data.
- The exponent, slot and symbol latched on a SOP beat apply from that beat's data onward. Beats of the previous symbol still in the pipeline keep their own exponent: the per-beat shift amounts are carried through the pipe.
- Back-to-back symbols are allowed: an eop beat may be followed by a sop beat in the next cycle with no gap.
- Reset values are 0 for every output, including o_err_cnt.
- A reset mid-symbol returns the FSM to IDLE with re_cnt=0. The pipeline valid bits are cleared, so o_tvalid=0 from the cycle after reset is sampled. No o_eop is emitted for the aborted symbol.

## Configuration
- ANT_AGC_ROUND_EN defined: rounding as above (add 2^(d-1) before the shift).
- ANT_AGC_ROUND_EN undefined: truncation only (y = x >>> d, and 0 for d>=16). Latency stays 3 cycles; stage 2 is a plain register.

## Test plan
- Clean symbol: even_agc=5, odd_agc=5; 1584 beats with addr 0..1583, SOP on beat 0, EOP on beat 1583 -> data passes unchanged, o_exp=5, o_sop/o_eop 3 cycles after the inputs, o_err_cnt=0.
- Alignment: even_agc=3, odd_agc=6, even I=0x0064 (100), Q=0xFF9B (-101) -> even I=13, Q=-13 (with rounding); without ANT_AGC_ROUND_EN, I=12, Q=-13; odd group unchanged; o_exp=6.
- Large difference: even_agc=0, odd_agc=20, even I=0x7FFF -> even output 0, odd unchanged.
- Short symbol: EOP at addr 99 -> o_eop on that beat, o_frm_err pulse, o_err_cnt=1, FSM back to IDLE. The next SOP is accepted.
- Framing errors:
  - A stray beat in IDLE -> o_err_cnt+1.
  - An addr jump 10->12 -> error pulse with data still forwarded.
  - A SOP at RE 500 -> error pulse and the symbol restarts with the new exponents.
- Reset mid-symbol at RE 700 -> all outputs 0 on the next cycle. A new symbol afterwards aligns correctly.

Source files
------------

// File: rtl/ant_agc_align.sv
// Aligns the even/odd antenna groups to one common AGC exponent per symbol and checks symbol framing.
// Build option ANT_AGC_ROUND_EN: round-half-up before each shift; otherwise shifts truncate.
module ant_agc_align #(
    parameter int ANT        = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int RE_NUM     = 1584,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [ANT*32-1:0]     i_ant_even,
    input  logic [ANT*32-1:0]     i_ant_odd,
    input  logic [ADDR_WIDTH-1:0] i_ant_addr,
    input  logic                  i_ant_sop,
    input  logic                  i_ant_eop,
    input  logic                  i_tvalid,
    input  logic [15:0]           i_info_1,
    input  logic [6:0]            i_slot_idx,
    input  logic [3:0]            i_symb_idx,
    output logic [2*ANT*32-1:0]   o_ant_data,
    output logic [7:0]            o_exp,
    output logic [6:0]            o_slot_idx,
    output logic [3:0]            o_symb_idx,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic                  o_tvalid,
    output logic                  o_frm_err,
    output logic [ERR_WIDTH-1:0]  o_err_cnt
);
    localparam int LANES     = 4 * ANT;
    localparam int GRP_LANES = 2 * ANT;
    localparam logic [ADDR_WIDTH-1:0] RE_LAST = ADDR_WIDTH'(RE_NUM - 1);
`ifdef ANT_AGC_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    function automatic logic signed [16:0] round_add(input logic signed [15:0] x, input logic [7:0] d);
        logic signed [16:0] bias;
        bias = '0;
        if (ROUND_EN && d >= 8'd1 && d <= 8'd15)
            bias = 17'sd1 <<< (d[3:0] - 4'd1);
        return $signed({x[15], x}) + bias;
    endfunction

    function automatic logic signed [15:0] shift_out(input logic signed [16:0] s, input logic [7:0] d);
        if (d == 8'd0)
            return s[15:0];
        else if (d >= 8'd16)
            return '0;
        else
            return 16'(s >>> d[3:0]);
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] re_cnt;
    logic [7:0]            agc_even, agc_odd;
    logic [6:0]            slot_lat;
    logic [3:0]            symb_lat;

    logic                  fwd, fwd_sop, fwd_eop, err;
    logic [7:0]            cur_even, cur_odd, cur_max;
    logic [6:0]            cur_slot;
    logic [3:0]            cur_symb;

    logic [2*ANT*32-1:0]   data_p0;
    logic [7:0]            d_even_p0, d_odd_p0, d_even_p1, d_odd_p1;
    logic [7:0]            exp_p0, exp_p1;
    logic [6:0]            slot_p0, slot_p1;
    logic [3:0]            symb_p0, symb_p1;
    logic signed [16:0]    sum_p1 [LANES];
    logic                  vld_p0, sop_p0, eop_p0, vld_p1, sop_p1, eop_p1;

    always_comb begin
        fwd     = 1'b0;
        fwd_sop = 1'b0;
        fwd_eop = 1'b0;
        err     = 1'b0;
        if (i_tvalid) begin
            if (i_ant_sop) begin
                fwd     = 1'b1;
                fwd_sop = 1'b1;
                err     = (state == RUN);
            end else if (state == IDLE) begin
                err = 1'b1;
            end else begin
                fwd     = 1'b1;
                fwd_eop = i_ant_eop || (re_cnt == RE_LAST);
                err     = (i_ant_addr != re_cnt) || (i_ant_eop != (re_cnt == RE_LAST));
            end
        end
        // A SOP beat already uses the exponents it carries
        cur_even = fwd_sop ? i_info_1[7:0]  : agc_even;
        cur_odd  = fwd_sop ? i_info_1[15:8] : agc_odd;
        cur_slot = fwd_sop ? i_slot_idx : slot_lat;
        cur_symb = fwd_sop ? i_symb_idx : symb_lat;
        cur_max  = (cur_even > cur_odd) ? cur_even : cur_odd;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            re_cnt    <= '0;
            agc_even  <= '0;
            agc_odd   <= '0;
            slot_lat  <= '0;
            symb_lat  <= '0;
            o_frm_err <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            o_frm_err <= err;
            if (err && o_err_cnt != '1)
                o_err_cnt <= o_err_cnt + ERR_WIDTH'(1);
            if (fwd_sop) begin
                state    <= RUN;
                re_cnt   <= ADDR_WIDTH'(1);
                agc_even <= cur_even;
                agc_odd  <= cur_odd;
                slot_lat <= cur_slot;
                symb_lat <= cur_symb;
            end else if (fwd) begin
                if (fwd_eop) begin
                    state  <= IDLE;
                    re_cnt <= '0;
                end else begin
                    re_cnt <= re_cnt + ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            vld_p0 <= 1'b0;
            sop_p0 <= 1'b0;
            eop_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            sop_p1 <= 1'b0;
            eop_p1 <= 1'b0;
        end else begin
            vld_p0 <= fwd;
            sop_p0 <= fwd_sop;
            eop_p0 <= fwd_eop;
            vld_p1 <= vld_p0;
            sop_p1 <= sop_p0;
            eop_p1 <= eop_p0;
        end
    end

    // Stage 1: register data with its per-beat shift amounts
    always_ff @(posedge i_clk) begin
        if (fwd) begin
            data_p0   <= {i_ant_odd, i_ant_even};
            d_even_p0 <= cur_max - cur_even;
            d_odd_p0  <= cur_max - cur_odd;
            exp_p0    <= cur_max;
            slot_p0   <= cur_slot;
            symb_p0   <= cur_symb;
        end
    end

    // Stage 2: rounding add
    always_ff @(posedge i_clk) begin
        if (vld_p0) begin
            for (int k = 0; k < LANES; k++)
                sum_p1[k] <= round_add(data_p0[16*k +: 16], (k < GRP_LANES) ? d_even_p0 : d_odd_p0);
            d_even_p1 <= d_even_p0;
            d_odd_p1  <= d_odd_p0;
            exp_p1    <= exp_p0;
            slot_p1   <= slot_p0;
            symb_p1   <= symb_p0;
        end
    end

    // Stage 3: arithmetic shift into the output register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_ant_data <= '0;
            o_exp      <= '0;
            o_slot_idx <= '0;
            o_symb_idx <= '0;
            o_tvalid   <= 1'b0;
            o_sop      <= 1'b0;
            o_eop      <= 1'b0;
        end else begin
            o_tvalid <= vld_p1;
            o_sop    <= vld_p1 && sop_p1;
            o_eop    <= vld_p1 && eop_p1;
            if (vld_p1) begin
                for (int k = 0; k < LANES; k++)
                    o_ant_data[16*k +: 16] <= shift_out(sum_p1[k], (k < GRP_LANES) ? d_even_p1 : d_odd_p1);
            end
            if (vld_p1 && sop_p1) begin
                o_exp      <= exp_p1;
                o_slot_idx <= slot_p1;
                o_symb_idx <= symb_p1;
            end
        end
    end
endmodule

// File: tb/tb_ant_agc_align.sv
// Randomized bench for ant_agc_align: per-cycle expectations from a spec-level model, checked at negedge.
// Define ANT_AGC_ROUND_EN consistently for DUT and bench.
module tb_ant_agc_align;
    localparam int ANT     = 4;
    localparam int ADDR_W  = 11;
    localparam int RE_NUM  = 1584;
    localparam int ERR_W   = 4;
    localparam int CNT_MAX = (1 << ERR_W) - 1;
`ifdef ANT_AGC_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic                 i_clk;
    logic                 i_reset_n;
    logic [ANT*32-1:0]    i_ant_even, i_ant_odd;
    logic [ADDR_W-1:0]    i_ant_addr;
    logic                 i_ant_sop, i_ant_eop, i_tvalid;
    logic [15:0]          i_info_1;
    logic [6:0]           i_slot_idx;
    logic [3:0]           i_symb_idx;
    logic [2*ANT*32-1:0]  o_ant_data;
    logic [7:0]           o_exp;
    logic [6:0]           o_slot_idx;
    logic [3:0]           o_symb_idx;
    logic                 o_sop, o_eop, o_tvalid, o_frm_err;
    logic [ERR_W-1:0]     o_err_cnt;

    ant_agc_align #(.ANT(ANT), .ADDR_WIDTH(ADDR_W), .RE_NUM(RE_NUM), .ERR_WIDTH(ERR_W)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ant_even(i_ant_even), .i_ant_odd(i_ant_odd),
        .i_ant_addr(i_ant_addr), .i_ant_sop(i_ant_sop), .i_ant_eop(i_ant_eop), .i_tvalid(i_tvalid),
        .i_info_1(i_info_1), .i_slot_idx(i_slot_idx), .i_symb_idx(i_symb_idx),
        .o_ant_data(o_ant_data), .o_exp(o_exp), .o_slot_idx(o_slot_idx), .o_symb_idx(o_symb_idx),
        .o_sop(o_sop), .o_eop(o_eop), .o_tvalid(o_tvalid), .o_frm_err(o_frm_err), .o_err_cnt(o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        bit                  v;
        bit                  sop;
        bit                  eop;
        logic [2*ANT*32-1:0] data;
        logic [7:0]          ex;
        logic [6:0]          sl;
        logic [3:0]          sy;
    } beat_t;

    beat_t exp_q   [int];
    bit    exp_err [int];
    int    exp_cnt [int];
    bit    zero_at [int];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    bit         m_in_sym = 1'b0;
    int         m_next = 0;
    logic [7:0] m_agc_e = '0, m_agc_o = '0;
    logic [6:0] m_slot = '0;
    logic [3:0] m_symb = '0;
    int         m_cnt = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Exponent alignment of one component as plain integer arithmetic (floor division)
    function automatic int ref_lane(input int x, input int d);
        int m, n, q;
        if (d == 0) return x;
        if (d >= 16) return 0;
        m = 1 << d;
        n = ROUND ? x + m / 2 : x;
        q = n / m;
        if ((n % m) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [ANT*32-1:0] rnd_grp();
        logic [ANT*32-1:0] r;
        for (int j = 0; j < ANT; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive(input bit rn, input bit v, input bit sop, input bit eop, input int addr,
                         input logic [ANT*32-1:0] ev, input logic [ANT*32-1:0] od,
                         input logic [15:0] info, input logic [6:0] sl, input logic [3:0] sy);
        beat_t b;
        bit err, fwd, last;
        int emax, de, dd;
        logic [2*ANT*32-1:0] din;
        logic signed [15:0] xs;
        i_reset_n = rn; i_tvalid = v; i_ant_sop = sop; i_ant_eop = eop;
        i_ant_addr = ADDR_W'(addr); i_ant_even = ev; i_ant_odd = od;
        i_info_1 = info; i_slot_idx = sl; i_symb_idx = sy;
        b = '{default: '0};
        err = 1'b0;
        fwd = 1'b0;
        if (!rn) begin
            m_in_sym = 1'b0;
            m_cnt = 0;
            for (int k = 1; k <= 3; k++) exp_q[cyc + k] = b;
            zero_at[cyc + 1] = 1'b1;
            exp_err[cyc + 1] = 1'b0;
            exp_cnt[cyc + 1] = 0;
        end else begin
            if (v && sop) begin
                err = m_in_sym;
                m_in_sym = 1'b1;
                m_next = 1;
                m_agc_e = info[7:0];
                m_agc_o = info[15:8];
                m_slot = sl;
                m_symb = sy;
                fwd = 1'b1;
                b.sop = 1'b1;
            end else if (v && !m_in_sym) begin
                err = 1'b1;
            end else if (v) begin
                last = (m_next == RE_NUM - 1);
                err = (addr != m_next) || (eop != last);
                b.eop = eop || last;
                fwd = 1'b1;
                if (b.eop) m_in_sym = 1'b0;
                else m_next++;
            end
            if (fwd) begin
                emax = (m_agc_e > m_agc_o) ? int'(m_agc_e) : int'(m_agc_o);
                de = emax - int'(m_agc_e);
                dd = emax - int'(m_agc_o);
                din = {od, ev};
                for (int k = 0; k < 4 * ANT; k++) begin
                    xs = din[16*k +: 16];
                    b.data[16*k +: 16] = 16'(ref_lane(int'(xs), (k < 2 * ANT) ? de : dd));
                end
                b.v = 1'b1;
                b.ex = 8'(emax);
                b.sl = m_slot;
                b.sy = m_symb;
            end
            exp_q[cyc + 3] = b;
            if (err && m_cnt < CNT_MAX) m_cnt++;
            exp_err[cyc + 1] = err;
            exp_cnt[cyc + 1] = m_cnt;
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b0, bit'($urandom_range(1)), bit'($urandom_range(1)), $urandom_range(2047),
                  rnd_grp(), rnd_grp(), 16'($urandom), 7'($urandom), 4'($urandom));
    endtask

    task automatic stray(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b1, 1'b0, bit'($urandom_range(1)), $urandom_range(2047),
                  rnd_grp(), rnd_grp(), 16'($urandom), 7'($urandom), 4'($urandom));
    endtask

    task automatic symbol(input logic [15:0] info, input int n, input int eop_at, input int bad_at,
                          input int resop_at, input logic [15:0] info2, input int rst_at,
                          input int pin, input bit gaps);
        logic [ANT*32-1:0] ev;
        logic [15:0] inf;
        int base, addr;
        bit sop;
        base = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(7) == 0) idle(1);
            if (i == rst_at) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, '0, '0, '0, '0);
                return;
            end
            ev = rnd_grp();
            if (i == 0 && pin == 1) ev = {ANT{16'hFF9B, 16'h0064}};
            if (i == 0 && pin == 2) ev = {ANT{16'h8000, 16'h7FFF}};
            if (i == resop_at) base = i;
            sop = (i == 0) || (i == resop_at);
            addr = (i == bad_at) ? i - base + 1 : i - base;
            inf = (i == 0) ? info : ((i == resop_at) ? info2 : 16'($urandom));
            drive(1'b1, 1'b1, sop, (i == eop_at), addr, ev, rnd_grp(), inf, 7'($urandom), 4'($urandom));
        end
    endtask

    always @(negedge i_clk) begin : cmp_blk
        beat_t b;
        int c;
        c = cyc;
        if (exp_err.exists(c)) begin
            chk("frm_err", 256'(o_frm_err), 256'(exp_err[c]));
            chk("err_cnt", 256'(o_err_cnt), 256'(exp_cnt[c]));
        end
        if (exp_q.exists(c)) begin
            b = exp_q[c];
            chk("tvalid", 256'(o_tvalid), 256'(b.v));
            chk("sop", 256'(o_sop), 256'(b.sop));
            chk("eop", 256'(o_eop), 256'(b.eop));
            if (b.v) begin
                chk("data", 256'(o_ant_data), 256'(b.data));
                chk("exp", 256'(o_exp), 256'(b.ex));
                chk("slot", 256'(o_slot_idx), 256'(b.sl));
                chk("symb", 256'(o_symb_idx), 256'(b.sy));
            end
        end
        if (zero_at.exists(c)) begin
            chk("rst_data", 256'(o_ant_data), 256'(0));
            chk("rst_exp", 256'(o_exp), 256'(0));
            chk("rst_slot", 256'(o_slot_idx), 256'(0));
            chk("rst_symb", 256'(o_symb_idx), 256'(0));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: cycle %0d reached, expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, '0, '0, '0, '0);

        // Hand-computed values that pin the reference model
`ifdef ANT_AGC_ROUND_EN
        chk("pin_pos_d3", 256'(ref_lane(100, 3)), 256'(13));
`else
        chk("pin_pos_d3", 256'(ref_lane(100, 3)), 256'(12));
`endif
        chk("pin_neg_d3", 256'(ref_lane(-101, 3)), 256'(-13));
        chk("pin_big_d20", 256'(ref_lane(32767, 20)), 256'(0));
        chk("pin_pass_d0", 256'(ref_lane(-5, 0)), 256'(-5));

        symbol({8'd5, 8'd5}, RE_NUM, RE_NUM - 1, -1, -1, '0, -1, 0, 1'b0);
        symbol({8'd6, 8'd3}, RE_NUM, RE_NUM - 1, -1, -1, '0, -1, 1, 1'b1);
        idle(5);
        @(negedge i_clk);
        chk("lit_cnt_clean", 256'(o_err_cnt), 256'(0));

        symbol({8'd20, 8'd0}, 100, 99, -1, -1, '0, -1, 2, 1'b0);
        idle(5);
        @(negedge i_clk);
        chk("lit_cnt_short", 256'(o_err_cnt), 256'(1));

        stray(1);
        symbol(16'($urandom), RE_NUM, RE_NUM - 1, 11, -1, '0, -1, 0, 1'b1);
        symbol(16'($urandom), 500 + RE_NUM, 500 + RE_NUM - 1, -1, 500, 16'($urandom), -1, 0, 1'b1);
        symbol(16'($urandom), RE_NUM, RE_NUM - 1, -1, -1, '0, 700, 0, 1'b0);
        @(negedge i_clk);
        chk("lit_rst_tvalid", 256'(o_tvalid), 256'(0));
        chk("lit_rst_cnt", 256'(o_err_cnt), 256'(0));
        chk("lit_rst_data", 256'(o_ant_data), 256'(0));
        idle(2);

        symbol({8'($urandom_range(40)), 8'($urandom_range(40))}, RE_NUM, RE_NUM - 1, -1, -1, '0, -1, 0, 1'b1);
        symbol(16'($urandom), RE_NUM, -1, -1, -1, '0, -1, 0, 1'b0);
        stray(1);
        symbol({8'($urandom_range(20)), 8'($urandom_range(20))}, RE_NUM, RE_NUM - 1, -1, -1, '0, -1, 0, 1'b1);
        stray(20);
        idle(5);
        @(negedge i_clk);
        chk("lit_cnt_sat", 256'(o_err_cnt), 256'(CNT_MAX));
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
